// File: rtl/debug_bridge_pkg.sv
// Shared types and field helpers for the debug write bridge.
// A buffered entry is {addr, data}; the control word carries the CPU-reset and overflow-clear bits.
package debug_bridge_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

  // Entry field slices
  localparam int unsigned ENTRY_ADDR_MSB = 31;
  localparam int unsigned ENTRY_ADDR_LSB = 16;
  localparam int unsigned ENTRY_DATA_MSB = 15;
  localparam int unsigned ENTRY_DATA_LSB = 0;

  // Control register bit positions
  localparam int unsigned CTRL_CPU_RST = 0;
  localparam int unsigned CTRL_OVF_CLR = 1;

  // Bridge FSM encoding
  typedef logic [0:0] state_t;
  localparam state_t StIdle = 1'b0;
  localparam state_t StReq  = 1'b1;

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [ADDR_W-1:0] addr,
                                                    input logic [DATA_W-1:0] data);
    return {addr, data};
  endfunction

  function automatic logic [ADDR_W-1:0] entry_addr(input logic [ENTRY_W-1:0] entry);
    return entry[ENTRY_ADDR_MSB:ENTRY_ADDR_LSB];
  endfunction

  function automatic logic [DATA_W-1:0] entry_data(input logic [ENTRY_W-1:0] entry);
    return entry[ENTRY_DATA_MSB:ENTRY_DATA_LSB];
  endfunction

endpackage

// File: rtl/debug_fifo.sv
// Single-clock FIFO buffering debug writes; full is derived from the registered count only,
// so a pop in the same cycle never makes room for a push.
module debug_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/debug_write_bridge.sv
// Buffers debug write strobes and replays them in order onto a req/ack bus; writes to CTRL_ADDR
// are consumed locally to drive the CPU reset line and clear the sticky overflow flag.
module debug_write_bridge
  import debug_bridge_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [15:0] CTRL_ADDR    = 16'hFFFF,
  parameter logic        CPU_RST_INIT = 1'b0
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        dbg_wr_i,
  input  logic [15:0] dbg_waddr_i,
  input  logic [15:0] dbg_wdata_i,
  output logic        mem_req_o,
  output logic [15:0] mem_addr_o,
  output logic [15:0] mem_data_o,
  input  logic        mem_ack_i,
  output logic        cpu_reset_o,
  output logic        overflow_o,
  output logic        busy_o
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [ENTRY_W-1:0] head_entry;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_data;
  logic [CntW-1:0]    fifo_count;
  logic               fifo_full, fifo_empty, fifo_pop;

  state_t             state_q, state_d;
  logic               req_q, req_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               cpu_rst_q, cpu_rst_d;
  logic               ovf_q, ovf_d;
  logic               ovf_set, ovf_clr;

  debug_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .push_i    (dbg_wr_i),
    .wdata_i   (pack_entry(dbg_waddr_i, dbg_wdata_i)),
    .pop_i     (fifo_pop),
    .rdata_o   (head_entry),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign head_addr = entry_addr(head_entry);
  assign head_data = entry_data(head_entry);

  // A strobe arriving while full is lost; the FIFO ignores it on its own
  assign ovf_set = dbg_wr_i & fifo_full;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    addr_d    = addr_q;
    data_d    = data_q;
    cpu_rst_d = cpu_rst_q;
    fifo_pop  = 1'b0;
    ovf_clr   = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          if (head_addr == CTRL_ADDR) begin
            fifo_pop  = 1'b1;
            cpu_rst_d = head_data[CTRL_CPU_RST];
            ovf_clr   = head_data[CTRL_OVF_CLR];
          end else begin
            // Entry stays queued until acknowledged so busy_o and full stay accurate
            addr_d  = head_addr;
            data_d  = head_data;
            req_d   = 1'b1;
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (mem_ack_i) begin
          req_d    = 1'b0;
          fifo_pop = 1'b1;
          state_d  = StIdle;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = StIdle;
      end
    endcase

    // Set has priority over a clear landing in the same cycle
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= StIdle;
      req_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      cpu_rst_q <= CPU_RST_INIT;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      cpu_rst_q <= cpu_rst_d;
      ovf_q     <= ovf_d;
    end
  end

  assign mem_req_o   = req_q;
  assign mem_addr_o  = addr_q;
  assign mem_data_o  = data_q;
  assign cpu_reset_o = cpu_rst_q;
  assign overflow_o  = ovf_q;
  assign busy_o      = (fifo_count != '0) | (state_q == StReq);

endmodule

// File: tb/tb_debug_write_bridge.sv
// Self-checking bench for debug_write_bridge: directed scenarios plus randomized fill/drain rounds
// checked against a transaction-level model of the queue, overflow flag and CPU reset line.
module tb_debug_write_bridge;

  localparam int unsigned DEPTH = 4;
  localparam logic [15:0] CTRL  = 16'hFFFF;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        dbg_wr_i = 1'b0;
  logic [15:0] dbg_waddr_i = '0;
  logic [15:0] dbg_wdata_i = '0;
  logic        mem_ack_i = 1'b0;
  logic        mem_req_o;
  logic [15:0] mem_addr_o;
  logic [15:0] mem_data_o;
  logic        cpu_reset_o;
  logic        overflow_o;
  logic        busy_o;

  always #5 sys_clk = ~sys_clk;

  debug_write_bridge #(
    .FIFO_DEPTH   (DEPTH),
    .CTRL_ADDR    (CTRL),
    .CPU_RST_INIT (1'b1)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .dbg_wr_i    (dbg_wr_i),
    .dbg_waddr_i (dbg_waddr_i),
    .dbg_wdata_i (dbg_wdata_i),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_ack_i   (mem_ack_i),
    .cpu_reset_o (cpu_reset_o),
    .overflow_o  (overflow_o),
    .busy_o      (busy_o)
  );

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] obs_q[$];
  logic [31:0] exp_q[$];
  int          stab_err = 0;
  int          last_cyc = 0;
  bit          ack_auto = 1'b0;
  int          ack_lat = 0;
  logic        cpu_m;
  logic        ovf_m;

  // Automatic acknowledger: ack rises after ack_lat full cycles of req
  initial begin
    int w = 0;
    forever begin
      @(negedge sys_clk);
      if (ack_auto) begin
        if (!mem_req_o) begin
          mem_ack_i = 1'b0;
          w = 0;
        end else if (w >= ack_lat) begin
          mem_ack_i = 1'b1;
        end else begin
          mem_ack_i = 1'b0;
          w++;
        end
      end
    end
  end

  // Bus monitor just before each rising edge: logs handshakes and payload stability
  initial begin
    logic        prev_req = 1'b0;
    int          cyc = 0;
    logic [15:0] held_a = '0;
    logic [15:0] held_d = '0;
    forever begin
      @(negedge sys_clk);
      #4;
      if (mem_req_o) begin
        if (!prev_req) begin
          held_a = mem_addr_o;
          held_d = mem_data_o;
          cyc = 1;
        end else begin
          cyc++;
          if (mem_addr_o !== held_a || mem_data_o !== held_d) stab_err++;
        end
        if (mem_ack_i) begin
          obs_q.push_back({mem_addr_o, mem_data_o});
          last_cyc = cyc;
          prev_req = 1'b0;
        end else begin
          prev_req = 1'b1;
        end
      end else begin
        prev_req = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge sys_clk);
    #2;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    dbg_wr_i = 1'b1;
    dbg_waddr_i = a;
    dbg_wdata_i = d;
    tick();
    dbg_wr_i = 1'b0;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    tick();
    cpu_m = 1'b1;
    ovf_m = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string tag);
    int i = 0;
    while (busy_o && i < max) begin
      tick();
      i++;
    end
    n_checks++;
    if (busy_o !== 1'b0) $display("FAIL %s_drain_timeout busy=%b after %0d cycles", tag, busy_o, i);
    else n_pass++;
  endtask

  task automatic cmp_obs(input string tag);
    logic [31:0] got;
    n_checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL %s_count got %0d writes exp %0d", tag, obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : 32'hxxxx_xxxx;
      n_checks++;
      if (got !== exp_q[i]) $display("FAIL %s_write%0d got %h exp %h", tag, i, got, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    tick();
    n_checks++; if (mem_req_o !== 1'b0) $display("FAIL rst_req got %b exp 0", mem_req_o); else n_pass++;
    n_checks++; if (mem_addr_o !== 16'h0) $display("FAIL rst_addr got %h exp 0", mem_addr_o); else n_pass++;
    n_checks++; if (mem_data_o !== 16'h0) $display("FAIL rst_data got %h exp 0", mem_data_o); else n_pass++;
    n_checks++; if (cpu_reset_o !== 1'b1) $display("FAIL rst_cpu got %b exp 1", cpu_reset_o); else n_pass++;
    n_checks++; if (overflow_o !== 1'b0) $display("FAIL rst_ovf got %b exp 0", overflow_o); else n_pass++;
    sys_rst_n = 1'b1;
    tick();
    n_checks++; if (busy_o !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy_o); else n_pass++;
    cpu_m = 1'b1;
    ovf_m = 1'b0;
  endtask

  task automatic test_single();
    ack_auto = 1'b1;
    ack_lat = 0;
    obs_q.delete();
    wr(16'h0100, 16'hBEEF);
    n_checks++; if (mem_req_o !== 1'b0) $display("FAIL single_req_n got %b exp 0", mem_req_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b1) $display("FAIL single_busy_n got %b exp 1", busy_o); else n_pass++;
    tick();
    n_checks++; if (mem_req_o !== 1'b1) $display("FAIL single_req_n1 got %b exp 1", mem_req_o); else n_pass++;
    n_checks++; if (mem_addr_o !== 16'h0100) $display("FAIL single_addr got %h exp 0100", mem_addr_o); else n_pass++;
    n_checks++; if (mem_data_o !== 16'hBEEF) $display("FAIL single_data got %h exp beef", mem_data_o); else n_pass++;
    tick();
    n_checks++; if (mem_req_o !== 1'b0) $display("FAIL single_req_n2 got %b exp 0", mem_req_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL single_busy_after got %b exp 0", busy_o); else n_pass++;
    n_checks++; if (last_cyc !== 1) $display("FAIL single_req_len got %0d exp 1", last_cyc); else n_pass++;
  endtask

  task automatic test_hold();
    ack_auto = 1'b1;
    ack_lat = 3;
    stab_err = 0;
    obs_q.delete();
    exp_q.delete();
    exp_q.push_back({16'h0200, 16'h1234});
    wr(16'h0200, 16'h1234);
    wait_idle(30, "hold");
    n_checks++; if (last_cyc !== 4) $display("FAIL hold_req_len got %0d exp 4", last_cyc); else n_pass++;
    n_checks++; if (stab_err !== 0) $display("FAIL hold_stable got %0d changes exp 0", stab_err); else n_pass++;
    cmp_obs("hold");
  endtask

  task automatic test_overflow();
    logic [15:0] d;
    ack_auto = 1'b0;
    mem_ack_i = 1'b0;
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      d = 16'($urandom);
      if (i < int'(DEPTH)) exp_q.push_back({16'h0300 + 16'(i), d});
      wr(16'h0300 + 16'(i), d);
    end
    tick();
    n_checks++; if (overflow_o !== 1'b1) $display("FAIL ovf_set got %b exp 1", overflow_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b1) $display("FAIL ovf_busy got %b exp 1", busy_o); else n_pass++;
    ack_auto = 1'b1;
    ack_lat = int'($urandom_range(0, 2));
    wait_idle(60, "ovf");
    cmp_obs("ovf");
    wr(CTRL, 16'h0002);
    tick();
    n_checks++; if (overflow_o !== 1'b0) $display("FAIL ovf_clear got %b exp 0", overflow_o); else n_pass++;
    n_checks++; if (cpu_reset_o !== 1'b0) $display("FAIL ovf_cpu got %b exp 0", cpu_reset_o); else n_pass++;
    n_checks++; if (obs_q.size() != 4) $display("FAIL ovf_ctrl_on_bus got %0d writes exp 4", obs_q.size()); else n_pass++;
  endtask

  task automatic test_order();
    int i = 0;
    int acks_at_fall = -1;
    do_reset();
    n_checks++; if (cpu_reset_o !== 1'b1) $display("FAIL order_init got %b exp 1", cpu_reset_o); else n_pass++;
    ack_auto = 1'b1;
    ack_lat = 1;
    obs_q.delete();
    exp_q.delete();
    exp_q.push_back({16'h0000, 16'hAAAA});
    exp_q.push_back({16'h0001, 16'hBBBB});
    wr(16'h0000, 16'hAAAA);
    wr(16'h0001, 16'hBBBB);
    wr(CTRL, 16'h0000);
    while (cpu_reset_o && i < 40) begin
      tick();
      i++;
    end
    if (!cpu_reset_o) acks_at_fall = obs_q.size();
    n_checks++; if (acks_at_fall !== 2) $display("FAIL order_fall got %0d acks exp 2", acks_at_fall); else n_pass++;
    wait_idle(20, "order");
    cmp_obs("order");
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    ack_auto = 1'b0;
    mem_ack_i = 1'b0;
    obs_q.delete();
    wr(16'h0400, 16'h1111);
    wr(16'h0401, 16'h2222);
    n_checks++; if (mem_req_o !== 1'b1) $display("FAIL rmid_pre_req got %b exp 1", mem_req_o); else n_pass++;
    #1 sys_rst_n = 1'b0;
    #1;
    n_checks++; if (mem_req_o !== 1'b0) $display("FAIL rmid_req got %b exp 0", mem_req_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL rmid_busy got %b exp 0", busy_o); else n_pass++;
    tick();
    sys_rst_n = 1'b1;
    ack_auto = 1'b1;
    ack_lat = 0;
    repeat (10) begin
      tick();
      if (mem_req_o !== 1'b0) seen++;
    end
    n_checks++; if (seen !== 0) $display("FAIL rmid_no_req got %0d req cycles exp 0", seen); else n_pass++;
    n_checks++; if (obs_q.size() != 0) $display("FAIL rmid_no_write got %0d exp 0", obs_q.size()); else n_pass++;
    n_checks++; if (cpu_reset_o !== 1'b1) $display("FAIL rmid_cpu got %b exp 1", cpu_reset_o); else n_pass++;
    cpu_m = 1'b1;
    ovf_m = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    ack_auto = 1'b0;
    mem_ack_i = 1'b0;
    obs_q.delete();
    exp_q.delete();
    for (int i = 1; i <= 5; i++) exp_q.push_back({16'h0500 + 16'(i), 16'hA000 + 16'(i)});
    wr(16'h0501, 16'hA001);
    wr(16'h0502, 16'hA002);
    wr(16'h0503, 16'hA003);
    // Three queued, first in flight: strobe coincides with the ack pop
    mem_ack_i = 1'b1;
    wr(16'h0504, 16'hA004);
    mem_ack_i = 1'b0;
    n_checks++; if (overflow_o !== 1'b0) $display("FAIL b2b_cnt3_ovf got %b exp 0", overflow_o); else n_pass++;
    wr(16'h0505, 16'hA005);
    tick();
    // Now four queued: the coincident strobe must be dropped
    mem_ack_i = 1'b1;
    wr(16'h0506, 16'hA006);
    mem_ack_i = 1'b0;
    n_checks++; if (overflow_o !== 1'b1) $display("FAIL b2b_cnt4_ovf got %b exp 1", overflow_o); else n_pass++;
    ack_auto = 1'b1;
    ack_lat = int'($urandom_range(0, 3));
    wait_idle(60, "b2b");
    cmp_obs("b2b");
    ovf_m = 1'b1;
  endtask

  task automatic test_random();
    int          k;
    logic [15:0] a, d;
    logic [1:0]  c;
    for (int r = 0; r < 4; r++) begin
      ack_auto = 1'b0;
      mem_ack_i = 1'b0;
      obs_q.delete();
      exp_q.delete();
      k = int'($urandom_range(1, 7));
      for (int i = 0; i < k; i++) begin
        a = 16'($urandom_range(0, 16'hFFFE));
        d = 16'($urandom);
        if (i < int'(DEPTH)) exp_q.push_back({a, d});
        else ovf_m = 1'b1;
        wr(a, d);
      end
      tick();
      n_checks++; if (overflow_o !== ovf_m) $display("FAIL rnd%0d_ovf got %b exp %b", r, overflow_o, ovf_m); else n_pass++;
      ack_auto = 1'b1;
      ack_lat = int'($urandom_range(0, 3));
      wait_idle(200, "rnd");
      cmp_obs("rnd");
      c = 2'($urandom_range(0, 3));
      wr(CTRL, {14'($urandom), c});
      cpu_m = c[0];
      if (c[1]) ovf_m = 1'b0;
      tick();
      n_checks++; if (cpu_reset_o !== cpu_m) $display("FAIL rnd%0d_cpu got %b exp %b", r, cpu_reset_o, cpu_m); else n_pass++;
      n_checks++; if (overflow_o !== ovf_m) $display("FAIL rnd%0d_ovf_ctrl got %b exp %b", r, overflow_o, ovf_m); else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_hold();
    test_overflow();
    test_order();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
